imm_decode_stage: RTL
=====================

Name: imm_decode_stage

Overview:
- Registered immediate-decode stage between fetch and execute in the RV32IM core.
- Classifies each instruction's format from its opcode, reassembles the scattered immediate fields, and drives the existing 12/20-bit sign extender with the field and select it needs.
- Applies the per-format shift and buffers the result in a 2-entry elastic buffer with valid/ready handshakes on both sides, so execute-side stalls never drop an instruction.

Parameters:
- Inst_Size, 32, width of instruction, PC and immediate.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered entries; takes priority over all other events.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; equals state != TWO and rst == 0.
- in_instr  in  Inst_Size  raw instruction.
- in_pc  in  Inst_Size  PC of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_instr  out  Inst_Size  head instruction.
- out_pc  out  Inst_Size  head PC.
- out_imm  out  Inst_Size  final immediate.
- out_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- out_illegal  out  1  opcode not in RV32IM base set.

Behaviour:
- Reset (rst=1 at edge): state=EMPTY, out_valid=0, all out_* data=0, in_ready=0 while rst is high, in_ready=1 from the first cycle after rst deasserts.
- Handshakes:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Head data holds stable while out_valid=1 and out_ready=0.
- Format decode on in_instr[6:0]:
  - 0010011, 0000011, 1100111, 1110011, 0001111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - 0110011 -> R.
  - Anything else -> illegal: fmt=7, illegal=1, imm=0. The entry is still enqueued.
- Extender drive (combinational, on the enqueue path):
  - I: Imm12=instr[31:20], control=0.
  - S: Imm12={instr[31:25],instr[11:7]}, control=0.
  - B: Imm12={instr[31],instr[7],instr[30:25],instr[11:8]}, control=0; imm=ext<<1.
  - J: Imm20={instr[31],instr[19:12],instr[20],instr[30:21]}, control=1; imm=ext<<1.
  - U: extender unused; imm={instr[31:12],12'b0}.
  - R/illegal: imm=0.
- Shifts are logical, truncated to Inst_Size. The immediate is computed at enqueue and stored with the entry.
- Latency: 1 cycle from accept into an EMPTY buffer to out_valid=1.
- State machine (2 entries: head, skid; FIFO order preserved):
  - EMPTY: accept -> write head, go ONE.
  - ONE, accept & pop -> head <= new entry, stay ONE.
  - ONE, accept & !pop -> skid <= new entry, go TWO.
  - ONE, pop & !accept -> go EMPTY.
  - TWO (in_ready=0): pop -> head <= skid, go ONE.
- flush=1 at edge: next state EMPTY, out_valid=0 next cycle, a same-cycle accept is discarded, and a same-cycle pop still counts downstream (the head was consumed).
- rst wins over flush. Reset mid-operation discards all entries with no partial outputs.
- out_valid = state != EMPTY. in_ready and out_valid are registered-state functions with no combinational in-to-out path.

Test Plan:
- Reset then push 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, out_illegal=0.
- Push 0x123450B7 (lui) then 0xFE000EE3 (beq -4) back-to-back, out_ready=1 -> out_imm 0x12345000 fmt 4, then 0xFFFFFFFC fmt 3, with PCs matching and order preserved.
- Push 0x0010006F (jal +2048) -> out_imm=0x00000800, out_fmt=5.
- out_ready=0, push 3 instructions -> in_ready=0 after the second accept, the third is held upstream; then out_ready=1 -> three entries drain in order, one per cycle.
- State TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, neither the buffered entries nor the flushed-cycle instruction ever appear.
- Push opcode 0x7F (e.g. 0x0000007F) -> out_illegal=1, out_fmt=7, out_imm=0. Assert rst mid-stream with 2 entries held -> out_valid=0 and data=0 after the edge.

Source files
------------

// File: rtl/imm_decode_stage_if.sv
// Fetch-to-execute handshake bundle for the immediate-decode stage.
// The upstream fetch side and the downstream execute consumer share this one interface.
interface imm_decode_stage_if #(
    parameter int Inst_Size = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [Inst_Size-1:0] in_instr;
    logic [Inst_Size-1:0] in_pc;

    logic                 out_valid;
    logic                 out_ready;
    logic [Inst_Size-1:0] out_instr;
    logic [Inst_Size-1:0] out_pc;
    logic [Inst_Size-1:0] out_imm;
    logic [2:0]           out_fmt;
    logic                 out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered RV32IM immediate-decode stage: classifies the format, rebuilds the immediate
// and holds results in a two-entry head/skid buffer so execute stalls never drop work.
module imm_decode_stage #(
    parameter int Inst_Size = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    imm_decode_stage_if.slave   bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [Inst_Size-1:0] instr;
        logic [Inst_Size-1:0] pc;
        logic [Inst_Size-1:0] imm;
        logic [2:0]           fmt;
        logic                 illegal;
    } entry_t;

    // Shared 12/20-bit sign extender: control selects the 20-bit field.
    function automatic logic [Inst_Size-1:0] sign_ext(input logic [11:0] imm12,
                                                      input logic [19:0] imm20,
                                                      input logic        control);
        if (control)
            return {{(Inst_Size-20){imm20[19]}}, imm20};
        else
            return {{(Inst_Size-12){imm12[11]}}, imm12};
    endfunction

    state_t               state_q;
    entry_t               head_q;
    entry_t               skid_q;
    entry_t               enq_d;

    logic [11:0]          ext_imm12;
    logic [19:0]          ext_imm20;
    logic                 ext_control;
    logic [Inst_Size-1:0] ext_val;
    logic [2:0]           fmt_d;
    logic                 illegal_d;
    logic [Inst_Size-1:0] imm_d;

    logic                 accept;
    logic                 pop;

    always_comb begin
        ext_imm12   = '0;
        ext_imm20   = '0;
        ext_control = 1'b0;
        fmt_d       = FMT_ILL;
        illegal_d   = 1'b1;
        unique case (bus.in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                fmt_d     = FMT_I;
                illegal_d = 1'b0;
                ext_imm12 = bus.in_instr[31:20];
            end
            7'b0100011: begin
                fmt_d     = FMT_S;
                illegal_d = 1'b0;
                ext_imm12 = {bus.in_instr[31:25], bus.in_instr[11:7]};
            end
            7'b1100011: begin
                fmt_d     = FMT_B;
                illegal_d = 1'b0;
                ext_imm12 = {bus.in_instr[31], bus.in_instr[7],
                             bus.in_instr[30:25], bus.in_instr[11:8]};
            end
            7'b0110111, 7'b0010111: begin
                fmt_d     = FMT_U;
                illegal_d = 1'b0;
            end
            7'b1101111: begin
                fmt_d       = FMT_J;
                illegal_d   = 1'b0;
                ext_control = 1'b1;
                ext_imm20   = {bus.in_instr[31], bus.in_instr[19:12],
                               bus.in_instr[20], bus.in_instr[30:21]};
            end
            7'b0110011: begin
                fmt_d     = FMT_R;
                illegal_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign ext_val = sign_ext(ext_imm12, ext_imm20, ext_control);

    // B and J offsets are halfword-scaled; the shift drops the top bit.
    always_comb begin
        imm_d = '0;
        unique case (fmt_d)
            FMT_I, FMT_S: imm_d = ext_val;
            FMT_B, FMT_J: imm_d = ext_val << 1;
            FMT_U:        imm_d = {bus.in_instr[31:12], 12'b0};
            default:      imm_d = '0;
        endcase
    end

    always_comb begin
        enq_d.instr   = bus.in_instr;
        enq_d.pc      = bus.in_pc;
        enq_d.imm     = imm_d;
        enq_d.fmt     = fmt_d;
        enq_d.illegal = illegal_d;
    end

    assign bus.in_ready  = (state_q != TWO) && !rst;
    assign bus.out_valid = (state_q != EMPTY);
    assign accept        = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_q  <= enq_d;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_q <= enq_d;
                    end else if (accept) begin
                        skid_q  <= enq_d;
                        state_q <= TWO;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.out_instr   = head_q.instr;
    assign bus.out_pc      = head_q.pc;
    assign bus.out_imm     = head_q.imm;
    assign bus.out_fmt     = head_q.fmt;
    assign bus.out_illegal = head_q.illegal;
endmodule
